// File: rtl/exec_ctrl_pkg.sv
// rtl/exec_ctrl_pkg.sv - states, instruction field layout and index helpers for exec_ctrl
package exec_ctrl_pkg;

    localparam int IR_W   = 16;
    localparam int IDX_W  = 5;
    localparam int CLS_HI = 15;
    localparam int CLS_LO = 13;
    localparam int OP_HI  = 12;
    localparam int OP_LO  = 10;
    localparam int DST_HI = 9;
    localparam int DST_LO = 5;
    localparam int SRC_HI = 4;
    localparam int SRC_LO = 0;

    localparam logic [2:0] CLS_MOV  = 3'b000;
    localparam logic [2:0] CLS_MOVI = 3'b001;
    localparam logic [2:0] CLS_ALU  = 3'b010;
    localparam logic [2:0] CLS_ALUI = 3'b011;
    localparam logic [2:0] CLS_LD   = 3'b100;
    localparam logic [2:0] CLS_ST   = 3'b101;

    typedef enum logic [4:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC,
        S_X0,
        S_A0, S_A1, S_A2, S_A3,
        S_L0, S_L1, S_L2, S_L3,
        S_S0, S_S1, S_S2,
        S_DONE, S_FAULT
    } state_t;

    // The two I/O ports sit directly above the general registers.
    function automatic int p0_idx(input int num_regs);
        return num_regs;
    endfunction

    function automatic int p1_idx(input int num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/exec_ctrl_regdec.sv
// rtl/exec_ctrl_regdec.sv - register index to one-hot bus select with out-of-range flag
module exec_ctrl_regdec
    import exec_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NUM_REGS+1:0] onehot_o,
    output logic                oor_o
);

    localparam int MAX_IDX = p1_idx(NUM_REGS);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i <= MAX_IDX; i++) begin
            onehot_o[i] = (idx_i == IDX_W'(i));
        end
    end

    assign oor_o = (int'(idx_i) > MAX_IDX);

endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - Moore sequencing FSM for the shared-bus microcontroller
// Optional memory-wait timeout: define EXEC_CTRL_MFC_TIMEOUT_EN.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_REGS    = 4,
    parameter int CNT_W       = 16,
    parameter int MFC_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [IR_W-1:0]     ir,
    input  logic                mfc,
    output logic                pc_out_en,
    output logic                pc_inc,
    output logic                ir_in,
    output logic                mar_in,
    output logic                mdr_write,
    output logic                mdr_read,
    output logic                mdr_out,
    output logic                mem_en,
    output logic                mem_rw,
    output logic                alu_in0,
    output logic                alu_in1,
    output logic                alu_latch,
    output logic                alu_out_en,
    output logic [2:0]          alu_op,
    output logic                imm_out_en,
    output logic [DATA_W-1:0]   imm_data,
    output logic [NUM_REGS+1:0] reg_out_en,
    output logic [NUM_REGS+1:0] reg_in_en,
    output logic                done,
    output logic                fault,
    output logic [CNT_W-1:0]    retired_cnt
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   retired_q;
    logic [NUM_REGS+1:0] src_oh, dst_oh;
    logic               src_oor, dst_oor, dst_is_p1, bad_instr, timeout;
    logic [2:0]         cls;

    assign cls       = ir[CLS_HI:CLS_LO];
    assign alu_op    = ir[OP_HI:OP_LO];
    assign imm_data  = {{(DATA_W-5){ir[SRC_HI]}}, ir[SRC_HI:SRC_LO]};
    assign dst_is_p1 = (int'(ir[DST_HI:DST_LO]) == p1_idx(NUM_REGS));

    exec_ctrl_regdec #(.NUM_REGS(NUM_REGS)) u_src_dec (
        .idx_i(ir[SRC_HI:SRC_LO]), .onehot_o(src_oh), .oor_o(src_oor)
    );
    exec_ctrl_regdec #(.NUM_REGS(NUM_REGS)) u_dst_dec (
        .idx_i(ir[DST_HI:DST_LO]), .onehot_o(dst_oh), .oor_o(dst_oor)
    );

    // Immediate forms never look at src; ST only reads, so P1 is a legal dst.
    always_comb begin
        bad_instr = 1'b0;
        case (cls)
            CLS_MOV, CLS_ALU, CLS_LD: bad_instr = src_oor | dst_oor | dst_is_p1;
            CLS_MOVI, CLS_ALUI:       bad_instr = dst_oor | dst_is_p1;
            CLS_ST:                   bad_instr = src_oor | dst_oor;
            default:                  bad_instr = 1'b1;
        endcase
    end

`ifdef EXEC_CTRL_MFC_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MFC_TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              in_wait;

    assign in_wait = (state_q == S_F1) || (state_q == S_L1) || (state_q == S_S2);
    assign timeout = in_wait && !mfc && (wait_q == WAIT_W'(MFC_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || (state_d != state_q)) begin
            wait_q <= '0;
        end else if (in_wait) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (MFC_TIMEOUT == 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run) state_d = S_F0;
            S_F0:    state_d = S_F1;
            S_F1:    if (mfc) state_d = S_F2; else if (timeout) state_d = S_FAULT;
            S_F2:    state_d = S_F3;
            S_F3:    state_d = S_DEC;
            S_DEC: begin
                if (bad_instr)                               state_d = S_FAULT;
                else if (cls == CLS_MOV || cls == CLS_MOVI)  state_d = S_X0;
                else if (cls == CLS_ALU || cls == CLS_ALUI)  state_d = S_A0;
                else if (cls == CLS_LD)                      state_d = S_L0;
                else                                         state_d = S_S0;
            end
            S_X0:    state_d = S_DONE;
            S_A0:    state_d = S_A1;
            S_A1:    state_d = S_A2;
            S_A2:    state_d = S_A3;
            S_A3:    state_d = S_DONE;
            S_L0:    state_d = S_L1;
            S_L1:    if (mfc) state_d = S_L2; else if (timeout) state_d = S_FAULT;
            S_L2:    state_d = S_L3;
            S_L3:    state_d = S_DONE;
            S_S0:    state_d = S_S1;
            S_S1:    state_d = S_S2;
            S_S2:    if (mfc) state_d = S_DONE; else if (timeout) state_d = S_FAULT;
            S_DONE:  state_d = run ? S_F0 : S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DONE) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired_cnt = retired_q;

    always_comb begin
        pc_out_en = 1'b0; pc_inc = 1'b0; ir_in = 1'b0; mar_in = 1'b0;
        mdr_write = 1'b0; mdr_read = 1'b0; mdr_out = 1'b0;
        mem_en = 1'b0; mem_rw = 1'b0;
        alu_in0 = 1'b0; alu_in1 = 1'b0; alu_latch = 1'b0; alu_out_en = 1'b0;
        imm_out_en = 1'b0; reg_out_en = '0; reg_in_en = '0;
        done = 1'b0; fault = 1'b0;
        case (state_q)
            S_F0:    begin pc_out_en = 1'b1; mar_in = 1'b1; end
            S_F1:    mem_en = 1'b1;
            S_F2:    mdr_read = 1'b1;
            S_F3:    begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_X0: begin
                if (cls == CLS_MOVI) imm_out_en = 1'b1;
                else                 reg_out_en = src_oh;
                reg_in_en = dst_oh;
            end
            S_A0:    begin reg_out_en = dst_oh; alu_in0 = 1'b1; end
            S_A1: begin
                if (cls == CLS_ALUI) imm_out_en = 1'b1;
                else                 reg_out_en = src_oh;
                alu_in1 = 1'b1;
            end
            S_A2:    alu_latch = 1'b1;
            S_A3:    begin alu_out_en = 1'b1; reg_in_en = dst_oh; end
            S_L0:    begin reg_out_en = src_oh; mar_in = 1'b1; end
            S_L1:    mem_en = 1'b1;
            S_L2:    mdr_read = 1'b1;
            S_L3:    begin mdr_out = 1'b1; reg_in_en = dst_oh; end
            S_S0:    begin reg_out_en = dst_oh; mar_in = 1'b1; end
            S_S1:    begin reg_out_en = src_oh; mdr_write = 1'b1; end
            S_S2:    begin mem_en = 1'b1; mem_rw = 1'b1; end
            S_DONE:  begin pc_inc = 1'b1; done = 1'b1; end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule
